// File: rtl/aux_burst_rd_sched.sv
// aux_burst_rd_sched
//   Read-side scheduler for the receive aux/audio FIFO on the pixel clock.
//   Once per line, at hcnt==START_HCNT in horizontal blanking, it issues a
//   fixed BURST_LEN read burst. It chains further bursts, each after a
//   GAP_LEN-cycle gap and up to MAX_BURSTS per line, while the sample-left
//   field of the FIFO word is seen to wrap (decrease).
//
//   Optional build macro AUX_STAT_EN adds the statistics outputs
//   underrun_cnt and abort_cnt.
//
// Ports
//   fifo_clk   in   pixel clock, rising edge
//   sys_rst    in   synchronous active-high reset
//   hcnt/vcnt  in   raster counters
//   vde        in   active-picture enable (aborts a running sequence)
//   aempty     in   aux FIFO empty
//   adout      in   aux FIFO read data
//   rd_en      out  FIFO read enable (registered slot gated by !aempty)
//   audio_on   out  aux data was seen during the previous frame
//   busy       out  scheduler not idle
//   burst_num  out  bursts issued on the current/last line
//   underrun_cnt, abort_cnt (AUX_STAT_EN only) saturating underrun cycles,
//                wrapping abort count
module aux_burst_rd_sched #(
  parameter int DATA_W     = 12,
  parameter int LEFT_MSB   = 11,
  parameter int LEFT_LSB   = 8,
  parameter int HCNT_W     = 12,
  parameter int START_HCNT = 1530,
  parameter int BURST_LEN  = 32,
  parameter int GAP_LEN    = 4,
  parameter int MAX_BURSTS = 8
) (
  input  logic              fifo_clk,
  input  logic              sys_rst,
  input  logic [HCNT_W-1:0] hcnt,
  input  logic [HCNT_W-1:0] vcnt,
  input  logic              vde,
  input  logic              aempty,
  input  logic [DATA_W-1:0] adout,
  output logic              rd_en,
  output logic              audio_on,
  output logic              busy,
  output logic [3:0]        burst_num
`ifdef AUX_STAT_EN
  ,
  output logic [15:0]       underrun_cnt,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int LW = LEFT_MSB - LEFT_LSB + 1;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t          r_state, w_next;
  logic [5:0]      r_cnt;
  logic [3:0]      r_gcnt;
  logic [3:0]      r_burst_num;
  logic            r_rd_q, r_init, r_more, r_ck, r_audio_on;
  logic [LW-1:0]   r_l1, r_l2;
  logic [LW-1:0]   w_left;
  logic            w_start, w_abort, w_chain;
  logic            w_unused;

  assign w_left   = adout[LEFT_MSB:LEFT_LSB];
  assign w_unused = ^adout;

  assign w_start = (r_state == S_IDLE) && (hcnt == HCNT_W'(START_HCNT)) &&
                   r_init && !vde && !aempty;

  // State register
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state and transition strobes
  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    w_chain = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_BURST;
      S_BURST: begin
        if (vde) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_cnt == 6'(BURST_LEN - 1)) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (vde) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (r_gcnt == 4'(GAP_LEN - 1)) begin
          if (r_more && (r_burst_num < 4'(MAX_BURSTS)) && !aempty) begin
            w_chain = 1'b1;
            w_next  = S_BURST;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      r_cnt       <= '0;
      r_gcnt      <= '0;
      r_burst_num <= '0;
      r_rd_q      <= 1'b0;
      r_init      <= 1'b0;
      r_more      <= 1'b0;
      r_ck        <= 1'b0;
      r_audio_on  <= 1'b0;
      r_l1        <= '0;
      r_l2        <= '0;
    end else begin
      if (vde) r_init <= 1'b1;

      // Frame-level activity flag; the vcnt==0 clear beats a same-cycle set.
      if (vcnt == '0) begin
        r_audio_on <= r_ck;
        r_ck       <= 1'b0;
      end else if (!aempty) begin
        r_ck <= 1'b1;
      end

      // The read slot is exactly the set of BURST cycles.
      r_rd_q <= (w_next == S_BURST);

      if ((w_next == S_BURST) && (r_state != S_BURST)) begin
        r_cnt  <= '0;
        r_more <= 1'b0;
      end else if (r_state == S_BURST) begin
        r_cnt <= r_cnt + 6'd1;
        // A decrease between consecutive samples means the field wrapped.
        if (r_l1 < r_l2) r_more <= 1'b1;
      end

      if (r_state == S_BURST) begin
        r_gcnt <= '0;
        r_l1   <= w_left;
        r_l2   <= r_l1;
      end else if (r_state == S_GAP) begin
        r_gcnt <= r_gcnt + 4'd1;
      end

      if (w_start)
        r_burst_num <= 4'd1;
      else if (w_chain)
        r_burst_num <= r_burst_num + 4'd1;
      else if ((r_state == S_IDLE) && (hcnt == HCNT_W'(1)))
        r_burst_num <= '0;
    end
  end

`ifdef AUX_STAT_EN
  logic [15:0] r_underrun_cnt;
  logic [7:0]  r_abort_cnt;

  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      r_underrun_cnt <= '0;
      r_abort_cnt    <= '0;
    end else begin
      if (r_rd_q && aempty && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (w_abort)
        r_abort_cnt <= r_abort_cnt + 8'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
  assign abort_cnt    = r_abort_cnt;
`endif

  // An empty FIFO masks the strobe but the slot still runs its full length.
  assign rd_en     = r_rd_q & ~aempty;
  assign audio_on  = r_audio_on;
  assign busy      = (r_state != S_IDLE);
  assign burst_num = r_burst_num;

endmodule
